// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-command valid/ready to APB requester (SETUP -> ACCESS)
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT wait cycles with rsp_err.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [1:0]        cmd_size,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [1:0]        p_strobe,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  logic [1:0]        state;
  logic [DATA_W-1:0] mask;
  assign cmd_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign mask      = {{8{p_strobe == 2'd3}}, {8{p_strobe[1]}}, {8{p_strobe != 2'd0}}, 8'hff};
`ifdef APB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CW-1:0] cnt;
  logic          expired;
  assign expired = cnt == CW'(TIMEOUT - 1);
`endif
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      p_strobe  <= 2'b00;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef APB_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          if (cmd_valid) begin
            paddr    <= cmd_addr;
            pwrite   <= cmd_write;
            pwdata   <= cmd_wdata;
            p_strobe <= cmd_size;
            psel     <= 1'b1;
            penable  <= 1'b0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt     <= '0;
`endif
        end
        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata & mask;
          end
`ifdef APB_TIMEOUT_EN
          else if (expired) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else
            cnt <= cnt + 1'b1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: table-driven vectors with a response scoreboard queue
module tb_apb_master_bridge;
  logic        pclk = 1'b0;
  logic        preset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [1:0]  cmd_size = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [1:0]  p_strobe;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .pclk(pclk), .preset_n(preset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .p_strobe(p_strobe), .pready(pready), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic [31:0] pd;
    int          waits;
    logic        tmo;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] sb[$];
  int          compared = 0;
  int          mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run(input vec_t v, input bit b2b, output time t_acc, output time t_done);
    int n;
    logic [32:0] e;
    cmd_valid = 1'b1;
    cmd_write = v.w;
    cmd_addr  = v.a;
    cmd_wdata = v.d;
    cmd_size  = v.sz;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge pclk);
      n++;
    end
    chk("accept_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge pclk);
    t_acc = $time;
    sb.push_back({v.ee, v.er});
    @(negedge pclk);
    if (!b2b) cmd_valid = 1'b0;
    pready = 1'b0;
    chk("setup_psel", {31'b0, psel}, 32'd1);
    chk("setup_penable", {31'b0, penable}, 32'd0);
    chk("setup_paddr", paddr, v.a);
    chk("setup_pwrite", {31'b0, pwrite}, {31'b0, v.w});
    chk("setup_pwdata", pwdata, v.d);
    chk("setup_strobe", {30'b0, p_strobe}, {30'b0, v.sz});
    chk("setup_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("setup_busy", {31'b0, busy}, 32'd1);
    for (int i = 0; i <= v.waits; i++) begin
      @(negedge pclk);
      pready = !v.tmo && i == v.waits;
      prdata = pready ? v.pd : $urandom;
      chk("access_sel_en", {30'b0, psel, penable}, 32'd3);
      chk("access_paddr", paddr, v.a);
      chk("access_pwdata", pwdata, v.d);
      chk("access_strobe", {30'b0, p_strobe}, {30'b0, v.sz});
      chk("access_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("access_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge pclk);
    t_done = $time;
    @(negedge pclk);
    pready = 1'b0;
    prdata = $urandom;
    chk("done_sel_en", {30'b0, psel, penable}, 32'd0);
    chk("done_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("done_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, e[31:0]);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
    end
    if (!b2b) begin
      @(negedge pclk);
      chk("rsp_pulse_end", {31'b0, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    time ta, td, ta2, td2;
    vec_t v;
    vecs.push_back('{1'b1, 32'h10, 32'hA5A5_1234, 2'b11, 32'h0, 0, 1'b0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'h20, 32'h0, 2'b01, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'h24, 32'h0, 2'b00, 32'h1234_5678, 0, 1'b0, 32'h0000_0078, 1'b0});
    vecs.push_back('{1'b0, 32'h28, 32'h0, 2'b10, 32'hCAFE_F00D, 1, 1'b0, 32'h00FE_F00D, 1'b0});
    vecs.push_back('{1'b0, 32'h2C, 32'h0, 2'b11, 32'h89AB_CDEF, 2, 1'b0, 32'h89AB_CDEF, 1'b0});
    vecs.push_back('{1'b1, 32'hFFFF_FFFC, 32'h0BAD_F00D, 2'b00, 32'hFFFF_FFFF, 2, 1'b0, 32'h0, 1'b0});
`ifdef APB_TIMEOUT_EN
    vecs.push_back('{1'b0, 32'h40, 32'h0, 2'b11, 32'h1357_9BDF, 7, 1'b0, 32'h1357_9BDF, 1'b0});
    vecs.push_back('{1'b0, 32'h44, 32'h0, 2'b11, 32'hFFFF_FFFF, 7, 1'b1, 32'h0, 1'b1});
    vecs.push_back('{1'b1, 32'h48, 32'h5555_AAAA, 2'b01, 32'h0, 7, 1'b1, 32'h0, 1'b1});
`endif
    repeat (2) @(negedge pclk);
    chk("rst_psel_en", {30'b0, psel, penable}, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_strobe", {30'b0, p_strobe}, 32'd0);
    chk("rst_rsp", {30'b0, rsp_valid, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ready_busy", {30'b0, cmd_ready, busy}, 32'd2);
    preset_n = 1'b1;
    pready = 1'b1;
    @(negedge pclk);
    chk("idle_pready_ignored", {30'b0, rsp_valid, psel}, 32'd0);
    pready = 1'b0;
    foreach (vecs[k]) begin
      run(vecs[k], 1'b0, ta, td);
      if (k == 0) chk("zero_wait_latency", 32'(td - ta), 32'd20);
      if (k == 1) chk("three_wait_latency", 32'(td - ta), 32'd50);
    end
    run(vecs[2], 1'b1, ta, td);
    run(vecs[3], 1'b0, ta2, td2);
    chk("b2b_gap", 32'(ta2 - td), 32'd10);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h80;
    cmd_size  = 2'b11;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    chk("pre_rst_access", {30'b0, psel, penable}, 32'd3);
    preset_n = 1'b0;
    @(negedge pclk);
    preset_n = 1'b1;
    chk("mid_rst_sel_en", {30'b0, psel, penable}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_rsp", {31'b0, rsp_valid}, 32'd0);
    @(negedge pclk);
    chk("mid_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    v = '{1'b0, 32'h84, 32'h0, 2'b10, 32'hA1B2_C3D4, 1, 1'b0, 32'h00B2_C3D4, 1'b0};
    run(v, 1'b0, ta, td);
    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
